// File: rtl/lpm_mult.sv
// Parameterised multiply-add: result = dataa*datab + sum, with an optional
// N-stage output pipeline that has an asynchronous active-low clear.
module lpm_mult #(
    parameter int    lpm_widtha         = 8,
    parameter int    lpm_widthb         = 8,
    parameter int    lpm_widthp         = 16,
    parameter int    lpm_widths         = 1,
    parameter string lpm_representation = "UNSIGNED",
    parameter int    lpm_pipeline       = 0,
    parameter string lpm_hint           = "UNUSED",
    parameter string lpm_type           = "LPM_MULT"
) (
    input  logic                  clock,
    input  logic                  aclr_n,
    input  logic                  clken,
    input  logic [lpm_widtha-1:0] dataa,
    input  logic [lpm_widthb-1:0] datab,
    input  logic [lpm_widths-1:0] sum,
    output logic [lpm_widthp-1:0] result
);

    localparam int FULL_W    = lpm_widtha + lpm_widthb;
    localparam int SUM_USED  = (lpm_widths < FULL_W) ? lpm_widths : FULL_W;
    localparam bit IS_SIGNED = (lpm_representation == "SIGNED");
    // The informational strings are referenced only so they are not orphaned.
    localparam bit unused_info = (lpm_hint == "") && (lpm_type == "");

    logic [FULL_W-1:0]     a_ext;
    logic [FULL_W-1:0]     b_ext;
    logic [FULL_W-1:0]     s_ext;
    logic [FULL_W-1:0]     prod;
    logic [FULL_W-1:0]     t_full;
    logic [lpm_widthp-1:0] t_res;

    if (!IS_SIGNED && (lpm_representation != "UNSIGNED")) begin : g_bad_rep
        $error("lpm_mult: lpm_representation must be SIGNED or UNSIGNED");
    end

    // Extending both operands to the full product width makes the low
    // FULL_W bits of an unsigned multiply equal the exact signed product.
    genvar gi;
    for (gi = 0; gi < FULL_W; gi++) begin : g_ext
        if (gi < lpm_widtha) begin : g_a_in
            assign a_ext[gi] = dataa[gi];
        end else begin : g_a_fill
            assign a_ext[gi] = IS_SIGNED & dataa[lpm_widtha-1];
        end

        if (gi < lpm_widthb) begin : g_b_in
            assign b_ext[gi] = datab[gi];
        end else begin : g_b_fill
            assign b_ext[gi] = IS_SIGNED & datab[lpm_widthb-1];
        end

        if (gi < SUM_USED) begin : g_s_in
            assign s_ext[gi] = sum[gi];
        end else begin : g_s_fill
            assign s_ext[gi] = IS_SIGNED & sum[SUM_USED-1];
        end
    end

    assign prod   = a_ext * b_ext;
    assign t_full = prod + s_ext;

    // Narrow results wrap; wide results extend according to representation.
    for (gi = 0; gi < lpm_widthp; gi++) begin : g_res
        if (gi < FULL_W) begin : g_res_in
            assign t_res[gi] = t_full[gi];
        end else begin : g_res_fill
            assign t_res[gi] = IS_SIGNED & t_full[FULL_W-1];
        end
    end

    if (lpm_widthp < FULL_W) begin : g_t_trunc
        logic unused_t_msbs;
        assign unused_t_msbs = ^t_full[FULL_W-1:lpm_widthp];
    end

    if (lpm_widths > FULL_W) begin : g_sum_trunc
        logic unused_sum_msbs;
        assign unused_sum_msbs = ^sum[lpm_widths-1:FULL_W];
    end

    if (lpm_pipeline == 0) begin : g_comb
        // Clock, enable and clear have no role in the combinational build.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clock, clken, aclr_n};
        assign result      = t_res;
    end else begin : g_pipe
        logic [lpm_widthp-1:0] stage_reg [lpm_pipeline];

        always_ff @(posedge clock or negedge aclr_n) begin
            if (!aclr_n) begin
                for (int i = 0; i < lpm_pipeline; i++) begin
                    stage_reg[i] <= '0;
                end
            end else if (clken) begin
                stage_reg[0] <= t_res;
                for (int i = 1; i < lpm_pipeline; i++) begin
                    stage_reg[i] <= stage_reg[i-1];
                end
            end
        end

        assign result = stage_reg[lpm_pipeline-1];
    end

endmodule

// File: tb/tb_lpm_mult.sv
// Self-checking bench for lpm_mult: combinational configurations checked
// against literal and modelled values, plus a 2-stage pipeline scoreboard.
module tb_lpm_mult;

    logic        clock;
    logic        aclr_n;
    logic        clken;
    logic [7:0]  a8, b8, s8;
    logic [3:0]  a4, b4;
    logic [7:0]  s4;
    logic [7:0]  pa, pb, ps;
    logic [7:0]  r_s8;
    logic [15:0] r_u16;
    logic [15:0] r_s16;
    logic [7:0]  r_u4;
    logic [15:0] r_p2;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] comb_q[$];
    logic [31:0] pipe_q[$];

    lpm_mult #(.lpm_widtha(8), .lpm_widthb(8), .lpm_widthp(8), .lpm_widths(8),
               .lpm_representation("SIGNED"), .lpm_pipeline(0)) u_s8 (
        .clock(clock), .aclr_n(aclr_n), .clken(clken),
        .dataa(a8), .datab(b8), .sum(s8), .result(r_s8));

    lpm_mult #(.lpm_widtha(8), .lpm_widthb(8), .lpm_widthp(16), .lpm_widths(8),
               .lpm_representation("UNSIGNED"), .lpm_pipeline(0)) u_u16 (
        .clock(clock), .aclr_n(aclr_n), .clken(clken),
        .dataa(a8), .datab(b8), .sum(s8), .result(r_u16));

    lpm_mult #(.lpm_widtha(8), .lpm_widthb(8), .lpm_widthp(16), .lpm_widths(8),
               .lpm_representation("SIGNED"), .lpm_pipeline(0)) u_s16 (
        .clock(clock), .aclr_n(aclr_n), .clken(clken),
        .dataa(a8), .datab(b8), .sum(s8), .result(r_s16));

    lpm_mult #(.lpm_widtha(4), .lpm_widthb(4), .lpm_widthp(8), .lpm_widths(8),
               .lpm_representation("UNSIGNED"), .lpm_pipeline(0)) u_u4 (
        .clock(clock), .aclr_n(aclr_n), .clken(clken),
        .dataa(a4), .datab(b4), .sum(s4), .result(r_u4));

    lpm_mult #(.lpm_widtha(8), .lpm_widthb(8), .lpm_widthp(16), .lpm_widths(8),
               .lpm_representation("SIGNED"), .lpm_pipeline(2)) u_p2 (
        .clock(clock), .aclr_n(aclr_n), .clken(clken),
        .dataa(pa), .datab(pb), .sum(ps), .result(r_p2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic longint ext(input longint x, input int w, input bit sg);
        longint m;
        longint v;
        m = (longint'(1) << w) - 1;
        v = x & m;
        if (sg && (((v >> (w - 1)) & 1) != 0)) v = v - (longint'(1) << w);
        return v;
    endfunction

    // Reference: exact product, sum trimmed/extended, reduced mod 2^(wa+wb),
    // then reinterpreted and cut/extended to wp bits.
    function automatic logic [31:0] model(input int wa, input int wb, input int wp, input int ws,
                                          input bit sg, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] s);
        int     f;
        int     wsu;
        longint av, bv, sv, t;
        f   = wa + wb;
        wsu = (ws > f) ? f : ws;
        av  = ext(longint'(a), wa, sg);
        bv  = ext(longint'(b), wb, sg);
        sv  = ext(longint'(s), wsu, sg);
        t   = ext(av * bv + sv, f, sg);
        return 32'(t & ((longint'(1) << wp) - 1));
    endfunction

    typedef struct {
        int          inst;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[13] = '{
        '{0, 8'h01, 8'hFB, 8'h00, 16'h00FB},
        '{0, 8'h00, 8'h7F, 8'h00, 16'h0000},
        '{0, 8'hFD, 8'h05, 8'h00, 16'h00F1},
        '{0, 8'h10, 8'h10, 8'h00, 16'h0000},
        '{0, 8'h80, 8'hFF, 8'h00, 16'h0080},
        '{0, 8'h05, 8'h05, 8'hFD, 16'h0016},
        '{1, 8'hFF, 8'hFF, 8'h00, 16'hFE01},
        '{1, 8'hFF, 8'hFF, 8'hFF, 16'hFF00},
        '{2, 8'h80, 8'h80, 8'h00, 16'h4000},
        '{2, 8'h7F, 8'h80, 8'h00, 16'hC080},
        '{2, 8'hFF, 8'h01, 8'hFF, 16'hFFFE},
        '{3, 8'h03, 8'h04, 8'h05, 16'h0011},
        '{3, 8'h0F, 8'h0F, 8'hFF, 16'h00E0}
    };

    function automatic logic [31:0] comb_out(input int inst);
        case (inst)
            0:       return 32'(r_s8);
            1:       return 32'(r_u16);
            2:       return 32'(r_s16);
            default: return 32'(r_u4);
        endcase
    endfunction

    task automatic run_comb(input string phase);
        for (int i = 0; i < 13; i++) begin
            a8 = vecs[i].a; b8 = vecs[i].b; s8 = vecs[i].s;
            a4 = vecs[i].a[3:0]; b4 = vecs[i].b[3:0]; s4 = vecs[i].s;
            comb_q.push_back(32'(vecs[i].exp));
            #1;
            check($sformatf("%s_vec%0d", phase, i), comb_out(vecs[i].inst), comb_q.pop_front());
        end
        for (int i = 0; i < 10; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 8'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom); s4 = 8'($urandom);
            comb_q.push_back(model(8, 8, 8, 8, 1'b1, 32'(a8), 32'(b8), 32'(s8)));
            comb_q.push_back(model(8, 8, 16, 8, 1'b0, 32'(a8), 32'(b8), 32'(s8)));
            comb_q.push_back(model(8, 8, 16, 8, 1'b1, 32'(a8), 32'(b8), 32'(s8)));
            comb_q.push_back(model(4, 4, 8, 8, 1'b0, 32'(a4), 32'(b4), 32'(s4)));
            #1;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("%s_rnd%0d_i%0d", phase, i, k), comb_out(k), comb_q.pop_front());
            end
        end
    endtask

    task automatic pipe_step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                             input logic en, input string tag);
        @(negedge clock);
        pa = a; pb = b; ps = s; clken = en;
        @(posedge clock);
        if (en && aclr_n) begin
            void'(pipe_q.pop_front());
            pipe_q.push_back(model(8, 8, 16, 8, 1'b1, 32'(a), 32'(b), 32'(s)));
        end
        #1;
        check(tag, 32'(r_p2), pipe_q[0]);
    endtask

    initial begin
        aclr_n = 1'b0; clken = 1'b0;
        a8 = '0; b8 = '0; s8 = '0; a4 = '0; b4 = '0; s4 = '0;
        pa = '0; pb = '0; ps = '0;
        pipe_q = '{32'd0, 32'd0};
        #1;
        check("rst_state", 32'(r_p2), 32'd0);

        // Combinational builds under reset with clken held low.
        run_comb("comb_rst");

        // Reset wins over enabled clock edges.
        for (int i = 0; i < 3; i++) pipe_step(8'd9, 8'd9, 8'd0, 1'b1, $sformatf("p_in_rst%0d", i));

        @(negedge clock); clken = 1'b0; aclr_n = 1'b1;
        run_comb("comb_run");

        pipe_step(8'd7, 8'd6, 8'd0, 1'b1, "p_edge1");
        check("p_not_yet", 32'(r_p2), 32'd0);
        pipe_step(8'd0, 8'd0, 8'd0, 1'b1, "p_edge2");
        check("p_42", 32'(r_p2), 32'd42);
        for (int i = 0; i < 3; i++) pipe_step(8'd9, 8'd9, 8'd0, 1'b0, $sformatf("p_hold%0d", i));
        check("p_hold_42", 32'(r_p2), 32'd42);

        for (int i = 0; i < 30; i++) begin
            pipe_step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                      $sformatf("p_rnd%0d", i));
        end

        pipe_step(8'd3, 8'd5, 8'd0, 1'b1, "p_fill0");
        pipe_step(8'hFE, 8'd11, 8'd1, 1'b1, "p_fill1");
        #2;
        aclr_n = 1'b0;
        a8 = 8'hFD; b8 = 8'd7; s8 = 8'd0;
        #1;
        check("p_clr_now", 32'(r_p2), 32'd0);
        check("p_clr_comb", 32'(r_s16), 32'h0000FFEB);
        pipe_q = '{32'd0, 32'd0};
        pipe_step(8'd1, 8'd1, 8'd0, 1'b1, "p_clr_edge");

        @(negedge clock); clken = 1'b0; aclr_n = 1'b1;
        pipe_step(8'd2, 8'd3, 8'd0, 1'b1, "p_post1");
        check("p_post1_zero", 32'(r_p2), 32'd0);
        pipe_step(8'd4, 8'd5, 8'd0, 1'b1, "p_post2");
        check("p_post2_new", 32'(r_p2), 32'd6);
        pipe_step(8'd0, 8'd0, 8'd0, 1'b1, "p_post3");
        check("p_post3_new", 32'(r_p2), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lpm_mult.md
LPM_MULT -- requirements
Module: lpm_mult

Interface
REQ-001 SHALL have parameter lpm_widtha, default 8, width of dataa (>=1).
REQ-002 SHALL have parameter lpm_widthb, default 8, width of datab (>=1).
REQ-003 SHALL have parameter lpm_widthp, default 16, width of result (>=1).
REQ-004 SHALL have parameter lpm_widths, default 1, width of sum (>=1).
REQ-005 SHALL have parameter lpm_representation, default "UNSIGNED"; legal values "SIGNED" and "UNSIGNED".
REQ-006 SHALL have parameter lpm_pipeline, default 0, result latency in clock cycles (>=0).
REQ-007 SHALL have parameters lpm_hint, default "UNUSED", and lpm_type, default "LPM_MULT"; both are informational strings with no functional effect.
REQ-008 SHALL have port clock, input, 1, rising-edge clock for the pipeline registers.
REQ-009 SHALL have port aclr_n, input, 1; the reset is asynchronous and active-low, and it clears all pipeline registers.
REQ-010 SHALL have port clken, input, 1, pipeline clock enable (active high).
REQ-011 SHALL have port dataa, input, lpm_widtha, multiplicand.
REQ-012 SHALL have port datab, input, lpm_widthb, multiplier.
REQ-013 SHALL have port sum, input, lpm_widths, addend.
REQ-014 SHALL have port result, output, lpm_widthp, (dataa*datab)+sum.

Function
REQ-015 SHALL compute the full product P = dataa*datab at width F = lpm_widtha+lpm_widthb with no overflow.
- SIGNED: all operands are two's complement.
- UNSIGNED: all operands are zero-extended.
REQ-016 SHALL extend sum to F bits (sign-extend if SIGNED, zero-extend if UNSIGNED) and form T = P+sum modulo 2^F; if lpm_widths>F, only the low F bits of sum are used.
REQ-017 SHALL drive result with T[lpm_widthp-1:0] when lpm_widthp<=F, truncating MSBs; this wraps modulo 2^lpm_widthp.
REQ-018 SHALL sign-extend T when lpm_widthp>F and SIGNED, and zero-extend it when UNSIGNED.
REQ-019 When lpm_pipeline=0, the block SHALL be purely combinational; result SHALL follow the inputs in the same cycle, and clock, clken and aclr_n SHALL have no effect.
REQ-020 When lpm_pipeline=N>0, result SHALL equal T of the inputs sampled N enabled rising edges earlier, through an N-stage shift of lpm_widthp-bit registers.
REQ-021 A pipeline stage SHALL advance only on a rising clock edge with clken=1; with clken=0, all stages SHALL hold.
REQ-022 A constant clken=0 with lpm_pipeline=0 SHALL be legal and SHALL still produce combinational results.
REQ-023 The block SHALL be synthesizable.
- Any multiplier implementation is permitted.
- No internal state beyond the N pipeline stages.

Reset
REQ-024 While aclr_n=0, every pipeline stage and result SHALL be 0 immediately, independent of clock and clken.
REQ-025 Asserting aclr_n mid-operation SHALL discard all in-flight products.
REQ-026 After aclr_n rises, result SHALL stay 0 until N enabled edges have occurred.
REQ-027 When aclr_n=0 and a clock edge coincide, reset SHALL win.
REQ-028 Reset SHALL NOT affect the combinational (lpm_pipeline=0) configuration.

Verification
REQ-029 SIGNED 8x8->8, pipeline 0, sum=0; dataa=1, datab=-5 -> result 8'hFB; dataa=0, datab=8'h7F -> 8'h00; dataa=-3, datab=5 -> 8'hF1.
REQ-030 SIGNED 8x8->8, pipeline 0; dataa=16, datab=16 -> 8'h00 (wrap); dataa=-128, datab=-1 -> 8'h80.
REQ-031 UNSIGNED 8x8->16, pipeline 0; dataa=255, datab=255 -> 16'hFE01. SIGNED 8x8->16; dataa=-128, datab=-128 -> 16'h4000.
REQ-032 UNSIGNED 4x4->8, widths 8, pipeline 0; dataa=3, datab=4, sum=5 -> 8'h11.
REQ-033 SIGNED 8x8->16, pipeline 2; apply 7*6 with clken=1 -> result 42 after the 2nd edge, not before; hold clken=0 for 3 edges -> result unchanged.
REQ-034 Pipeline 2 with a valid product in flight; pulse aclr_n=0 between edges -> result 0 at once, stays 0 for 2 enabled edges after release, then shows new products.
